// File: rtl/fft_frame_buffer.sv
// Double-buffered FFT frame store: parallel capture of N complex samples, serial valid/ready readout.
// Optional FFT_BITREV_EN selects bit-reversed readout order (default build: linear order).
module fft_frame_buffer #(
  parameter int DW = 32,
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [N*DW-1:0]   din_r,
  input  logic [N*DW-1:0]   din_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*DW-1:0]   out_data,
  output logic [AW-1:0]     out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_STREAM = 1'b1;
  localparam logic [AW-1:0] LAST_CNT  = AW'(N - 1);

  logic [2*DW-1:0] bank0_r [N];
  logic [2*DW-1:0] bank1_r [N];

  logic [1:0]      full_r;
  logic [1:0]      full_nxt_s;
  logic            wr_sel_r;
  logic            wr_sel_nxt_s;
  logic            rd_sel_r;
  logic            rd_sel_nxt_s;
  logic [0:0]      state_r;
  logic [0:0]      state_nxt_s;
  logic [AW-1:0]   cnt_r;
  logic [AW-1:0]   cnt_nxt_s;
  logic [AW-1:0]   rd_cnt_s;
  logic [AW-1:0]   rd_addr_s;
  logic [2*DW-1:0] rd_word_s;
  logic            capture_s;
  logic            drop_s;
  logic            release_s;
  logic            valid_nxt_s;
  logic            busy_nxt_s;
  logic            last_nxt_s;
  logic [2*DW-1:0] data_nxt_s;
  logic [AW-1:0]   idx_nxt_s;

  // Readout order: bin index presented for stream position c.
  function automatic logic [AW-1:0] order_f(input logic [AW-1:0] c);
    logic [AW-1:0] r;
`ifdef FFT_BITREV_EN
    for (int b = 0; b < AW; b++) begin
      r[b] = c[AW-1-b];
    end
`else
    r = c;
`endif
    return r;
  endfunction

  // Write-side decisions: a load lands only when the bank under wr_sel is free.
  always_comb begin
    capture_s = load & ~full_r[wr_sel_r];
    drop_s    = load &  full_r[wr_sel_r];
  end

  // Read-side fetch of the word that the next beat will present.
  always_comb begin
    if (state_r == ST_STREAM) begin
      rd_cnt_s = cnt_r + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_cnt_s = {AW{1'b0}};
    end
    rd_addr_s = order_f(rd_cnt_s);
    if (rd_sel_r) begin
      rd_word_s = bank1_r[rd_addr_s];
    end else begin
      rd_word_s = bank0_r[rd_addr_s];
    end
  end

  // Read FSM next-state and output-register next values.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    valid_nxt_s = out_valid;
    busy_nxt_s  = busy;
    last_nxt_s  = out_last;
    data_nxt_s  = out_data;
    idx_nxt_s   = out_idx;
    release_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (full_r[rd_sel_r]) begin
          state_nxt_s = ST_STREAM;
          cnt_nxt_s   = {AW{1'b0}};
          valid_nxt_s = 1'b1;
          busy_nxt_s  = 1'b1;
          last_nxt_s  = (LAST_CNT == {AW{1'b0}});
          data_nxt_s  = rd_word_s;
          idx_nxt_s   = rd_addr_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (out_valid && out_ready) begin
          if (cnt_r == LAST_CNT) begin
            // Frame done: free the bank; the idle state supplies the one-cycle gap.
            release_s   = 1'b1;
            state_nxt_s = ST_IDLE;
            valid_nxt_s = 1'b0;
            busy_nxt_s  = 1'b0;
            last_nxt_s  = 1'b0;
          end else begin
            cnt_nxt_s   = rd_cnt_s;
            data_nxt_s  = rd_word_s;
            idx_nxt_s   = rd_addr_s;
            last_nxt_s  = (rd_cnt_s == LAST_CNT);
          end
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        last_nxt_s  = 1'b0;
      end
    endcase
  end

  // Bank ownership: release and capture never address the same bank on one edge.
  always_comb begin
    full_nxt_s = full_r;
    if (release_s) begin
      full_nxt_s[rd_sel_r] = 1'b0;
      rd_sel_nxt_s         = ~rd_sel_r;
    end else begin
      full_nxt_s[rd_sel_r] = full_r[rd_sel_r];
      rd_sel_nxt_s         = rd_sel_r;
    end
    if (capture_s) begin
      full_nxt_s[wr_sel_r] = 1'b1;
      wr_sel_nxt_s         = ~wr_sel_r;
    end else begin
      wr_sel_nxt_s         = wr_sel_r;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {AW{1'b0}};
      full_r    <= 2'b00;
      wr_sel_r  <= 1'b0;
      rd_sel_r  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= {(2*DW){1'b0}};
      out_idx   <= {AW{1'b0}};
      overrun   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      full_r    <= full_nxt_s;
      wr_sel_r  <= wr_sel_nxt_s;
      rd_sel_r  <= rd_sel_nxt_s;
      out_valid <= valid_nxt_s;
      busy      <= busy_nxt_s;
      out_last  <= last_nxt_s;
      out_data  <= data_nxt_s;
      out_idx   <= idx_nxt_s;
      overrun   <= drop_s;
    end
  end

  // Sample storage; contents are don't-care until a capture marks the bank full.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (capture_s && !wr_sel_r) begin
        bank0_r[k] <= {din_r[k*DW +: DW], din_i[k*DW +: DW]};
      end
      if (capture_s && wr_sel_r) begin
        bank1_r[k] <= {din_r[k*DW +: DW], din_i[k*DW +: DW]};
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer (N=8, DW=32) with a frame-queue reference model.
module tb_fft_frame_buffer;

  localparam int DW = 32;
  localparam int N  = 8;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load = 1'b0;
  logic [N*DW-1:0] din_r = '0;
  logic [N*DW-1:0] din_i = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [2*DW-1:0] out_data;
  logic [AW-1:0]   out_idx;
  logic            out_last;
  logic            busy;
  logic            overrun;

  int checks = 0;
  int errors = 0;

  fft_frame_buffer #(.DW(DW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .din_r(din_r), .din_i(din_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int ord(input int c);
    int r;
`ifdef FFT_BITREV_EN
    r = 0;
    for (int b = 0; b < AW; b++) r = r | (((c >> b) & 1) << (AW - 1 - b));
`else
    r = c;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of stored frames (front = frame being streamed).
  logic [63:0] wq[$];
  bit m_stream = 0;
  int m_beat = 0;
  bit m_ovr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq.delete();
      m_stream = 0;
      m_beat = 0;
      m_ovr = 0;
    end else begin
      int occ;
      bit s0;
      occ = wq.size() / N;
      s0 = m_stream;
      m_ovr = 0;
      if (s0 && out_ready) begin
        if (m_beat == N - 1) begin
          repeat (N) void'(wq.pop_front());
          m_stream = 0;
        end else begin
          m_beat = m_beat + 1;
        end
      end
      if (!s0 && occ > 0) begin
        m_stream = 1;
        m_beat = 0;
      end
      if (load) begin
        if (occ < 2) begin
          for (int k = 0; k < N; k++) wq.push_back({din_r[k*DW +: DW], din_i[k*DW +: DW]});
        end else begin
          m_ovr = 1;
        end
      end
    end
  end

  int beats = 0;
  int ovr_cnt = 0;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("valid", {63'd0, out_valid}, {63'd0, m_stream});
    chk("busy", {63'd0, busy}, {63'd0, m_stream});
    chk("overrun", {63'd0, overrun}, {63'd0, m_ovr});
    chk("last", {63'd0, out_last}, {63'd0, (m_stream && m_beat == N - 1)});
    if (m_stream) begin
      chk("data", out_data, wq[ord(m_beat)]);
      chk("idx", {61'd0, out_idx}, 64'(ord(m_beat)));
    end
    if (out_valid && out_ready) beats++;
    if (overrun) ovr_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [31:0] rbase, input logic [31:0] ibase);
    for (int k = 0; k < N; k++) begin
      din_r[k*DW +: DW] = rbase + 32'(k);
      din_i[k*DW +: DW] = ibase + 32'(k);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      step();
      n++;
    end
    if (busy) chk("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  int b0;
  int o0;
  logic [63:0] held;

  initial begin
    // Reset state
    step(); step();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_idx_last_busy_ovr", {60'd0, out_idx, out_last}, 64'd0);
    chk("rst_busy_ovr", {62'd0, busy, overrun}, 64'd0);
    rst_n = 1'b1;
    step();

    // Single frame, full throughput
    b0 = beats;
    set_frame(32'd1, 32'h100);
    load = 1'b1;
    step();
    load = 1'b0;
    chk("t1_not_yet_valid", {63'd0, out_valid}, 64'd0);
    step();
    chk("t1_beat0_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_beat0_data", out_data, 64'h00000001_00000100);
    chk("t1_beat0_idx", {61'd0, out_idx}, 64'd0);
    step();
`ifdef FFT_BITREV_EN
    chk("t1_beat1_data", out_data, 64'h00000005_00000104);
    chk("t1_beat1_idx", {61'd0, out_idx}, 64'd4);
`else
    chk("t1_beat1_data", out_data, 64'h00000002_00000101);
    chk("t1_beat1_idx", {61'd0, out_idx}, 64'd1);
`endif
    repeat (6) step();
    chk("t1_beat7_last", {63'd0, out_last}, 64'd1);
    chk("t1_beat7_data", out_data, 64'h00000008_00000107);
    chk("t1_beat7_idx", {61'd0, out_idx}, 64'd7);
    step();
    chk("t1_done_valid", {62'd0, out_valid, busy}, 64'd0);
    chk("t1_beat_count", 64'(beats - b0), 64'd8);

    // Backpressure at beat 2
    step();
    b0 = beats;
    set_frame(32'h200, 32'h300);
    load = 1'b1;
    step();
    load = 1'b0;
    step(); step(); step();
    chk("t2_beat2_idx", {61'd0, out_idx}, 64'(ord(2)));
    out_ready = 1'b0;
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_hold_data", out_data, held);
      chk("t2_hold_valid", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    wait_idle(30);
    chk("t2_beat_count", 64'(beats - b0), 64'd8);

    // Double buffering and overrun
    step();
    b0 = beats;
    o0 = ovr_cnt;
    set_frame(32'h400, 32'h500);
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    set_frame(32'h600, 32'h700);
    load = 1'b1;
    step();
    set_frame(32'h800, 32'h900);
    step();
    load = 1'b0;
    chk("t3_overrun_pulse", {63'd0, overrun}, 64'd1);
    step();
    chk("t3_overrun_clear", {63'd0, overrun}, 64'd0);
    wait_idle(30);
    chk("t3_gap", {63'd0, out_valid}, 64'd0);
    step();
    chk("t3_b_beat0", out_data, 64'h00000600_00000700);
    wait_idle(30);
    chk("t3_beat_count", 64'(beats - b0), 64'd16);
    chk("t3_overrun_count", 64'(ovr_cnt - o0), 64'd1);

    // Load on the same edge as the last accepted beat
    step();
    o0 = ovr_cnt;
    set_frame(32'hA00, 32'hB00);
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (8) step();
    chk("t4_last_showing", {63'd0, out_last}, 64'd1);
    set_frame(32'hC00, 32'hD00);
    load = 1'b1;
    step();
    load = 1'b0;
    chk("t4_gap", {63'd0, busy}, 64'd0);
    step();
    chk("t4_e_beat0", out_data, 64'h00000C00_00000D00);
    wait_idle(30);
    chk("t4_no_overrun", 64'(ovr_cnt - o0), 64'd0);

    // Reset mid-frame
    step();
    set_frame(32'hE00, 32'hF00);
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (5) step();
    chk("t5_beat4_idx", {61'd0, out_idx}, 64'(ord(4)));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_data", out_data, 64'd0);
    chk("t5_rst_ctrl", {58'd0, out_valid, busy, out_last, overrun, 2'b00}, 64'd0);
    chk("t5_rst_idx", {61'd0, out_idx}, 64'd0);
    step(); step();
    rst_n = 1'b1;
    b0 = beats;
    repeat (12) step();
    chk("t5_no_beats", 64'(beats - b0), 64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_buffer.md
# fft_frame_buffer

Parametrised, double-buffered frame store for FFT sample data: captures a full frame of N complex samples in one cycle and streams it out one complex word per cycle over a valid/ready handshake. It sits between the butterfly array's parallel outputs and the serial result path. A second frame can be captured while the previous one drains.

## Interface
Parameters:
- `DW`, 32: width of each real and each imaginary component.
- `N`, 8: samples per frame; a power of two, 2..64.
- `AW`, $clog2(N): index width. Derived; do not override.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `load` in 1: capture a frame this cycle.
- `din_r` in N*DW: real parts; sample k is at bits [k*DW +: DW].
- `din_i` in N*DW: imaginary parts, same packing.
- `out_valid` out 1: `out_data` holds a valid beat.
- `out_ready` in 1: downstream accepts the beat.
- `out_data` out 2*DW: {real, imag} of the current sample.
- `out_idx` out AW: frequency-bin index of the current beat.
- `out_last` out 1: current beat is the final beat of the frame.
- `busy` out 1: a frame is streaming.
- `overrun` out 1: one-cycle pulse when a load was dropped.

## Operation
- Storage: two banks (0, 1), each N x 2*DW. Each bank has a `full` flag. Write pointer `wr_sel` and read pointer `rd_sel` are 1 bit each.
- Capture: when `load`=1 at an edge and `bank[wr_sel]` is not full, all N samples are written to that bank, its `full` is set, and `wr_sel` toggles.
- Drop: when `load`=1 and `bank[wr_sel]` is already full (both banks full), the data is discarded and `overrun`=1 for the next cycle only. No other state changes.
- Read FSM, two states:
  - IDLE: if `bank[rd_sel]` is full, load the output register with entry order(0), set `out_valid`=1 and `busy`=1, counter=0, go to STREAM.
  - STREAM: on an edge with `out_valid`&&`out_ready`:
    - If counter < N-1: increment counter and present entry order(counter+1).
    - If counter = N-1: clear `bank[rd_sel]` full, toggle `rd_sel`, drop `out_valid` and `busy`, go to IDLE.
  - STREAM: while `out_ready`=0, `out_data`, `out_idx` and `out_last` hold stable.
- `out_idx` = order(counter). `out_last` = 1 exactly when counter = N-1 while in STREAM.
- No arithmetic on data; samples pass through bit-exact.

## Timing
- Reset values: `out_valid`, `out_data`, `out_idx`, `out_last`, `busy` and `overrun` are all 0. Both `full` flags are 0, `wr_sel`=`rd_sel`=0, FSM is in IDLE. Bank contents are not reset.
- Latency: `load` sampled at edge k gives `out_valid`=1 with beat 0 after edge k+1.
- Throughput: one beat per cycle while `out_ready`=1. A frame takes N cycles minimum.
- Frame-to-frame gap: exactly one idle cycle (`out_valid`=0) between the last beat of one frame and beat 0 of the next, even when the next bank is already full.
- Load on the same edge that the last beat is accepted: the capture targets `wr_sel`, which is never `rd_sel` while `rd_sel`'s bank is full. Both actions complete; no overrun.
- Reset asserted mid-frame: immediate abort. Outputs return to reset values, and the current frame and any pending frame are discarded.

## Configuration
- `FFT_BITREV_EN` defined: order(c) = bit-reverse of c over AW bits. Beats leave in natural frequency order from a radix-2 DIT/DIF array, and `out_idx` carries the reversed value.
- `FFT_BITREV_EN` undefined: order(c) = c, linear readout.

## Test plan
All scenarios use N=8 and DW=32.
- Single frame, linear order: load sample k with real=k+1, imag=0x100+k, hold `out_ready`=1. Expect 8 consecutive beats of {k+1, 0x100+k}, `out_idx` 0..7, `out_last` only on the 8th beat, first beat one cycle after the load edge.
- Bit-reverse (`FFT_BITREV_EN` defined): same frame. Expect `out_idx` sequence 0,4,2,6,1,5,3,7 with matching data.
- Backpressure: drop `out_ready` for 3 cycles at beat 2. Expect beat 2 held stable for all 3 cycles, no beat lost or duplicated.
- Double buffering: load frame A, then load frame B 2 cycles later, then attempt load C while both banks are full. Expect A streamed, then one gap cycle, then B streamed, and `overrun` high for exactly one cycle after the C attempt.
- Reset mid-frame: deassert `rst_n` at beat 4. Expect all outputs 0 immediately; after release, no beats appear until a new `load`.
